// File: rtl/mult_man_pkg.sv
// Shared definitions for the mult_man pipelined shift-and-add multiplier.
// Holds the default operand widths and the product-width helper, so the top
// and the stage cell size their datapaths the same way.
package mult_man_pkg;

  // Default multiplicand width.
  localparam int DEF_N = 8;
  // Default multiplier width, which is also the number of pipeline stages.
  localparam int DEF_M = 4;

  // Width of the unsigned product of an n-bit and an m-bit operand.
  // (2^n-1)*(2^m-1) < 2^(n+m), so n+m bits never truncate.
  function automatic int prod_width(input int n, input int m);
    return n + m;
  endfunction

endpackage : mult_man_pkg

// File: rtl/mult_man_stage.sv
// One pipeline cell of mult_man (stage IDX, 1 <= IDX <= M-1).
// The incoming multiplicand has already been shifted IDX-1 times. This cell
// shifts it once more and adds it to the running sum when multiplier bit IDX
// is set. The multiplier and valid flag ride along unchanged. Every field is
// captured on every edge, so a bubble in the pipeline is simply zeros.
module mult_man_stage
  import mult_man_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int M   = DEF_M,
  parameter int IDX = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [prod_width(N, M)-1:0] acc_in,
  input  logic [prod_width(N, M)-1:0] mcand_in,
  input  logic [M-1:0]                mplier_in,
  input  logic                        valid_in,
  output logic [prod_width(N, M)-1:0] acc_out,
  output logic [prod_width(N, M)-1:0] mcand_out,
  output logic [M-1:0]                mplier_out,
  output logic                        valid_out
);

  localparam int W = prod_width(N, M);

  logic [W-1:0] mcand_sh_s;
  logic [W-1:0] pp_s;
  logic [W-1:0] acc_nxt_s;

  logic [W-1:0] acc_r;
  logic [W-1:0] mcand_r;
  logic [M-1:0] mplier_r;
  logic         valid_r;

  // Shift the multiplicand up one place and form this stage's partial sum.
  always_comb begin
    mcand_sh_s = {W{1'b0}};
    pp_s       = {W{1'b0}};
    acc_nxt_s  = {W{1'b0}};
    mcand_sh_s = {mcand_in[W-2:0], 1'b0};
    if (mplier_in[IDX]) begin
      pp_s = mcand_sh_s;
    end else begin
      pp_s = {W{1'b0}};
    end
    acc_nxt_s = acc_in + pp_s;
  end

  // Pipeline register for this stage; async reset flushes in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r    <= {W{1'b0}};
      mcand_r  <= {W{1'b0}};
      mplier_r <= {M{1'b0}};
      valid_r  <= 1'b0;
    end else begin
      acc_r    <= acc_nxt_s;
      mcand_r  <= mcand_sh_s;
      mplier_r <= mplier_in;
      valid_r  <= valid_in;
    end
  end

  assign acc_out    = acc_r;
  assign mcand_out  = mcand_r;
  assign mplier_out = mplier_r;
  assign valid_out  = valid_r;

endmodule : mult_man_stage

// File: rtl/mult_man.sv
// mult_man: pipelined unsigned N x M shift-and-add multiplier.
// Stage 0 captures the operands and the partial product for mult2 bit 0.
// Stages 1..M-1 each add one more shifted partial product. A valid bit
// travels alongside each operand pair. A new pair may enter every clock and
// there is no backpressure. result/result_ready come straight from the last
// stage's flops, M register stages after capture.
module mult_man
  import mult_man_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        data_ready,
  input  logic [N-1:0]                mult1,
  input  logic [M-1:0]                mult2,
  output logic                        result_ready,
  output logic [prod_width(N, M)-1:0] result
);

  localparam int W = prod_width(N, M);

  // Pipeline buses: element i is the registered output of stage i.
  logic [W-1:0] acc_r    [M];
  logic [W-1:0] mcand_r  [M];
  logic [M-1:0] mplier_r [M];
  logic         valid_r  [M];

  // Stage 0 registers.
  logic [W-1:0] acc0_r;
  logic [W-1:0] mcand0_r;
  logic [M-1:0] mplier0_r;
  logic         valid0_r;

  logic [W-1:0] mult1_ext_s;
  logic [W-1:0] acc0_nxt_s;

  // Zero-extend the multiplicand and select the bit-0 partial product.
  always_comb begin
    mult1_ext_s = {W{1'b0}};
    acc0_nxt_s  = {W{1'b0}};
    mult1_ext_s = {{M{1'b0}}, mult1};
    if (mult2[0]) begin
      acc0_nxt_s = mult1_ext_s;
    end else begin
      acc0_nxt_s = {W{1'b0}};
    end
  end

  // Capture stage: load a new pair when data_ready, otherwise inject a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc0_r    <= {W{1'b0}};
      mcand0_r  <= {W{1'b0}};
      mplier0_r <= {M{1'b0}};
      valid0_r  <= 1'b0;
    end else if (data_ready) begin
      acc0_r    <= acc0_nxt_s;
      mcand0_r  <= mult1_ext_s;
      mplier0_r <= mult2;
      valid0_r  <= 1'b1;
    end else begin
      acc0_r    <= {W{1'b0}};
      mcand0_r  <= {W{1'b0}};
      mplier0_r <= {M{1'b0}};
      valid0_r  <= 1'b0;
    end
  end

  assign acc_r[0]    = acc0_r;
  assign mcand_r[0]  = mcand0_r;
  assign mplier_r[0] = mplier0_r;
  assign valid_r[0]  = valid0_r;

  // Stages 1..M-1, one partial product per multiplier bit.
  for (genvar gi = 1; gi < M; gi++) begin : g_stage
    mult_man_stage #(
      .N   (N),
      .M   (M),
      .IDX (gi)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .acc_in     (acc_r[gi-1]),
      .mcand_in   (mcand_r[gi-1]),
      .mplier_in  (mplier_r[gi-1]),
      .valid_in   (valid_r[gi-1]),
      .acc_out    (acc_r[gi]),
      .mcand_out  (mcand_r[gi]),
      .mplier_out (mplier_r[gi]),
      .valid_out  (valid_r[gi])
    );
  end

  // Outputs are the last stage's flops; there is no path from the inputs.
  assign result       = acc_r[M-1];
  assign result_ready = valid_r[M-1];

endmodule : mult_man

// File: tb/tb_mult_man.sv
// Self-checking bench for mult_man: default (8x4) and small (6x3) instances.
// The reference model records, at every rising edge, whether a pair was
// presented and its arithmetic product. The output after an edge must show
// the record from M-1 edges earlier, or zeros when no such record exists.
module tb_mult_man;

  localparam int N1 = 8;
  localparam int M1 = 4;
  localparam int N2 = 6;
  localparam int M2 = 3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 dr1;
  logic [N1-1:0]        a1;
  logic [M1-1:0]        b1;
  logic                 rr1;
  logic [N1+M1-1:0]     r1;
  logic                 dr2;
  logic [N2-1:0]        a2;
  logic [M2-1:0]        b2;
  logic                 rr2;
  logic [N2+M2-1:0]     r2;

  int n_checks = 0;
  int n_fail   = 0;

  int q1_v[$];
  int q1_p[$];
  int q2_v[$];
  int q2_p[$];

  always #5 clk = ~clk;

  mult_man #(.N(N1), .M(M1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_ready   (dr1),
    .mult1        (a1),
    .mult2        (b1),
    .result_ready (rr1),
    .result       (r1)
  );

  mult_man #(.N(N2), .M(M2)) dut_small (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_ready   (dr2),
    .mult1        (a2),
    .mult2        (b2),
    .result_ready (rr2),
    .result       (r2)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    q1_v.delete();
    q1_p.delete();
    q2_v.delete();
    q2_p.delete();
  endtask

  // Record what each DUT sees at this rising edge.
  task automatic model_edge();
    if (!rst_n) begin
      clear_model();
    end else begin
      q1_v.push_back(dr1 ? 1 : 0);
      q1_p.push_back(dr1 ? int'(a1) * int'(b1) : 0);
      if (q1_v.size() > M1) begin
        void'(q1_v.pop_front());
        void'(q1_p.pop_front());
      end
      q2_v.push_back(dr2 ? 1 : 0);
      q2_p.push_back(dr2 ? int'(a2) * int'(b2) : 0);
      if (q2_v.size() > M2) begin
        void'(q2_v.pop_front());
        void'(q2_p.pop_front());
      end
    end
  endtask

  task automatic compare(input string tag);
    int ev1 = 0;
    int ep1 = 0;
    int ev2 = 0;
    int ep2 = 0;
    if (q1_v.size() == M1) begin
      ev1 = q1_v[0];
      ep1 = q1_p[0];
    end
    if (q2_v.size() == M2) begin
      ev2 = q2_v[0];
      ep2 = q2_p[0];
    end
    check_eq({tag, "/rdy"},   64'(rr1), 64'(ev1));
    check_eq({tag, "/res"},   64'(r1),  64'(ep1));
    check_eq({tag, "/rdy_s"}, 64'(rr2), 64'(ev2));
    check_eq({tag, "/res_s"}, 64'(r2),  64'(ep2));
  endtask

  // Drive both DUTs on the falling edge, then check 1 ns after the rising edge.
  task automatic cycle(input string tag,
                       input logic d1, input logic [N1-1:0] x1, input logic [M1-1:0] y1,
                       input logic d2, input logic [N2-1:0] x2, input logic [M2-1:0] y2);
    @(negedge clk);
    dr1 = d1;
    a1  = x1;
    b1  = y1;
    dr2 = d2;
    a2  = x2;
    b2  = y2;
    @(posedge clk);
    model_edge();
    #1;
    compare(tag);
  endtask

  // Default DUT directed, small DUT random.
  task automatic cycle1(input string tag,
                        input logic d1, input logic [N1-1:0] x1, input logic [M1-1:0] y1);
    cycle(tag, d1, x1, y1,
          1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 3'($urandom_range(0, 7)));
  endtask

  int dir_a [4] = '{25, 16, 10, 15};
  int dir_b [4] = '{5, 10, 4, 7};
  int dir_p [4] = '{125, 160, 40, 105};
  int ext_a [3] = '{255, 0, 255};
  int ext_b [3] = '{15, 15, 0};
  int ext_p [3] = '{3825, 0, 0};
  int gat_d [3] = '{1, 0, 1};
  int gat_p [3] = '{15, 0, 14};
  int sw_b  [7] = '{7, 1, 15, 3, 11, 4, 9};

  initial begin
    rst_n = 1'b0;
    dr1 = 1'b0; a1 = '0; b1 = '0;
    dr2 = 1'b0; a2 = '0; b2 = '0;

    // Reset held with operands toggling: outputs stay zero.
    for (int i = 0; i < 3; i++) begin
      cycle("reset", 1'b1, 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)),
            1'b1, 6'($urandom_range(0, 63)), 3'($urandom_range(0, 7)));
    end
    rst_n = 1'b1;

    // Directed back-to-back pairs, then drain.
    for (int i = 0; i < 7; i++) begin
      if (i < 4) cycle1("dir", 1'b1, 8'(dir_a[i]), 4'(dir_b[i]));
      else       cycle1("dir", 1'b0, 8'd0, 4'd0);
      if (i >= 3) begin
        check_eq("dir_rdy", 64'(rr1), 64'd1);
        check_eq("dir_res", 64'(r1), 64'(dir_p[i-3]));
      end
    end

    // Extremes: full-scale product and zero operands.
    for (int i = 0; i < 6; i++) begin
      if (i < 3) cycle1("ext", 1'b1, 8'(ext_a[i]), 4'(ext_b[i]));
      else       cycle1("ext", 1'b0, 8'd0, 4'd0);
      if (i >= 3) begin
        check_eq("ext_rdy", 64'(rr1), 64'd1);
        check_eq("ext_res", 64'(r1), 64'(ext_p[i-3]));
      end
    end

    // Valid gating 1-0-1: gap cycle shows not-ready and zero.
    for (int i = 0; i < 6; i++) begin
      if (i == 0)      cycle1("gate", 1'b1, 8'd5, 4'd3);
      else if (i == 2) cycle1("gate", 1'b1, 8'd7, 4'd2);
      else             cycle1("gate", 1'b0, 8'd99, 4'd9);
      if (i >= 3) begin
        check_eq("gate_rdy", 64'(rr1), 64'(gat_d[i-3]));
        check_eq("gate_res", 64'(r1), 64'(gat_p[i-3]));
      end
    end

    // Small variant: 63 x 7 after 3 edges.
    for (int i = 0; i < 3; i++) begin
      cycle("small", 1'b0, 8'd0, 4'd0, (i == 0), 6'd63, 3'd7);
      if (i == 2) begin
        check_eq("small_rdy", 64'(rr2), 64'd1);
        check_eq("small_res", 64'(r2), 64'd441);
      end
    end

    // Sweep: mult1 increments through the 255->0 wrap for each mult2.
    for (int j = 0; j < 7; j++) begin
      for (int i = 0; i < 32; i++) begin
        cycle1("sweep", 1'b1, 8'((240 + i) % 256), 4'(sw_b[j]));
      end
    end

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      cycle1("rand", ($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
             4'($urandom_range(0, 15)));
    end

    // Fill with non-zero products, then reset mid-cycle.
    for (int i = 0; i < 4; i++) begin
      cycle("fill", 1'b1, 8'd200, 4'd15, 1'b1, 6'd50, 3'd5);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rdy",   64'(rr1), 64'd0);
    check_eq("async_res",   64'(r1),  64'd0);
    check_eq("async_rdy_s", 64'(rr2), 64'd0);
    check_eq("async_res_s", 64'(r2),  64'd0);
    clear_model();
    for (int i = 0; i < 2; i++) begin
      cycle("inreset", 1'b1, 8'd255, 4'd15, 1'b1, 6'd63, 3'd7);
    end
    rst_n = 1'b1;

    // Recovery after reset, then drain to idle.
    for (int i = 0; i < 20; i++) begin
      cycle1("post", ($urandom_range(0, 1) != 0), 8'($urandom_range(0, 255)),
             4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 6; i++) begin
      cycle("idle", 1'b0, 8'd0, 4'd0, 1'b0, 6'd0, 3'd0);
    end
    check_eq("idle_rdy", 64'(rr1), 64'd0);
    check_eq("idle_res", 64'(r1),  64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mult_man
